leaf_out_arbiter: RTL
=====================

Name: leaf_out_arbiter

Overview:
- Round-robin arbiter that lets NUM_REQ HLS operator output streams (ap_vld/ap_ack style) share one user-to-interface input port of leaf_interface.
- Grants one requester at a time for a burst of up to BURST_LEN words.
- Forwards words through a single registered output stage and tags each word with its source index, so the downstream packetizer can select the destination.
- Sits between the operator instances and leaf_interface inside a leaf.

Parameters:
- PAYLOAD_BITS, 32, payload width per word.
- NUM_REQ, 4, number of requesters (2..16).
- SRC_BITS, 4, width of source tag; must satisfy 2^SRC_BITS >= NUM_REQ.
- BURST_LEN, 8, maximum words accepted per grant (1..256).

Ports:
- clk_user  in  1  user clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  NUM_REQ*PAYLOAD_BITS  requester payloads; requester i uses bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- in_vld  in  NUM_REQ  per-requester word valid.
- in_ack  out  NUM_REQ  per-requester accept; combinational.
- out_data  out  PAYLOAD_BITS  registered payload to leaf_interface.
- out_src  out  SRC_BITS  registered index of the requester that produced out_data.
- out_vld  out  1  registered valid.
- out_ack  in  1  downstream accept.
- grant  out  NUM_REQ  registered one-hot current grant; all zeros when idle.

Behaviour:
- Transfer rules:
  - Input transfer: cycle where in_vld[i] && in_ack[i].
  - Output transfer: cycle where out_vld && out_ack.
- Reset (reset=0, asynchronous):
  - out_vld=0, out_data=0, out_src=0, grant=0, state=IDLE, burst count=0.
  - Last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
  - A word held in the output register is discarded.
- States: IDLE, BURST.
- IDLE:
  - grant=0, all in_ack=0.
  - If any in_vld is high, select the first requester with in_vld high, searching from pointer+1 and wrapping modulo NUM_REQ.
  - Register its one-hot grant, set pointer to it, clear count, go to BURST next cycle.
  - The arbitration decision costs exactly one cycle.
- BURST, granted requester g:
  - in_ack[g] = (~out_vld || out_ack). All other in_ack=0.
  - On an input transfer: out_data<=in_data[g], out_src<=g, out_vld<=1, count<=count+1.
  - If an output transfer occurs with no input transfer in the same cycle: out_vld<=0.
  - A simultaneous drain and fill gives one word per cycle, with no bubble.
- Release of grant (BURST -> IDLE, grant<=0 next cycle) when either:
  - (a) an input transfer occurs with count==BURST_LEN-1, or
  - (b) in_vld[g]==0 in any BURST cycle, which is an early release.
  - Backpressure (in_ack[g]=0 while in_vld[g]=1) does not release the grant and does not advance count.
- The output register drains independently of state: out_vld can remain 1 in IDLE until out_ack.
- While out_vld=1 and out_ack=0, out_data and out_src stay stable.
- Fairness: after a release, the next search starts at g+1, so a requester that keeps in_vld high cannot win twice while another requester is waiting.
- Latency: requester raises in_vld at cycle t (arbiter in IDLE, output empty) -> grant and in_ack at t+1 -> out_vld with data at t+2.
- Requester in_data and in_vld must be held until in_ack; the arbiter does not check this.
- NUM_REQ=1: behaves as one register stage with periodic one-cycle idle gaps (one per BURST_LEN words).

Test Plan:
- Single requester, BURST_LEN=4, in_vld[0] held high for 8 words 0x10..0x17, out_ack=1 -> out_data 0x10..0x13 on consecutive cycles, out_src=0. Then one IDLE gap cycle in the input acceptance (in_ack[0]=0) before regrant, then 0x14..0x17.
- Requesters 0 and 2 both continuously valid, BURST_LEN=4 -> grant alternates 0001, 0100, 0001... Each burst is 4 words; out_src pattern is 0,0,0,0,2,2,2,2.
- Backpressure: out_ack=0 for 5 cycles mid-burst -> out_data and out_src frozen, in_ack[g]=0, count unchanged. After out_ack=1, the burst resumes and completes with exactly BURST_LEN words total.
- Early release: requester 1 drops in_vld after 2 words while requester 3 is waiting -> grant moves to requester 3 after one IDLE cycle. Only 2 words are sourced from requester 1.
- Reset asserted mid-burst with out_vld=1 -> out_vld, grant and out_data are 0 immediately, without a clock edge. After release, requester 0 wins over requester 3 when both are valid.
- Wrap-around: pointer at NUM_REQ-1=3, requesters 0 and 3 valid -> requester 0 is granted first.

Source files
------------

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter that merges NUM_REQ ap_vld/ap_ack operator streams into one
// registered, source-tagged output stage feeding a leaf_interface input port.
module leaf_out_arbiter #(
    parameter int PAYLOAD_BITS = 32,
    parameter int NUM_REQ      = 4,
    parameter int SRC_BITS     = 4,
    parameter int BURST_LEN    = 8
) (
    input  logic                            clk_user,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] in_data,
    input  logic [NUM_REQ-1:0]              in_vld,
    output logic [NUM_REQ-1:0]              in_ack,
    output logic [PAYLOAD_BITS-1:0]         out_data,
    output logic [SRC_BITS-1:0]             out_src,
    output logic                            out_vld,
    input  logic                            out_ack,
    output logic [NUM_REQ-1:0]              grant
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [IDX_W-1:0]        r_gidx;      // current winner, and the round-robin pointer
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_REQ-1:0]      r_grant;
    logic [PAYLOAD_BITS-1:0] r_out_data;
    logic [SRC_BITS-1:0]     r_out_src;
    logic                    r_out_vld;

    logic [PAYLOAD_BITS-1:0] w_words [NUM_REQ];
    logic [IDX_W-1:0]        w_sel;
    logic                    w_any_vld;
    logic                    w_room;
    logic                    w_gvld;
    logic                    w_in_xfer;
    logic                    w_last;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_words[i] = in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    // Search begins just past the last winner, so a persistent requester yields to waiting ones.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_sel     = r_gidx;
        w_any_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_any_vld && in_vld[IDX_W'((int'(r_gidx) + k) % NUM_REQ)]) begin
                w_any_vld = 1'b1;
                w_sel     = IDX_W'((int'(r_gidx) + k) % NUM_REQ);
            end
        end
    end

    assign w_room    = ~r_out_vld | out_ack;
    assign w_gvld    = in_vld[r_gidx];
    assign w_in_xfer = (r_state == S_BURST) && w_gvld && w_room;
    assign w_last    = (r_cnt == CNT_W'(BURST_LEN - 1));

    always_ff @(posedge clk_user or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_vld) w_next_state = S_BURST;
            S_BURST: if (!w_gvld || (w_in_xfer && w_last)) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ack = '0;
        if (r_state == S_BURST) begin
            in_ack[r_gidx] = w_room;
        end
    end

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            r_grant <= '0;
            r_gidx  <= IDX_W'(NUM_REQ - 1);
            r_cnt   <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_any_vld) begin
                r_grant <= NUM_REQ'(1) << w_sel;
                r_gidx  <= w_sel;
                r_cnt   <= '0;
            end
        end else begin
            if (w_next_state == S_IDLE) begin
                r_grant <= '0;
            end
            if (w_in_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Data and tag load only on an input transfer, so they hold steady under backpressure.
    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            r_out_data <= '0;
            r_out_src  <= '0;
            r_out_vld  <= 1'b0;
        end else if (w_in_xfer) begin
            r_out_data <= w_words[r_gidx];
            r_out_src  <= SRC_BITS'(r_gidx);
            r_out_vld  <= 1'b1;
        end else if (out_ack) begin
            r_out_vld  <= 1'b0;
        end
    end

    assign out_data = r_out_data;
    assign out_src  = r_out_src;
    assign out_vld  = r_out_vld;
    assign grant    = r_grant;

endmodule
